// File: rtl/dpram_sync.sv
`timescale 1ns/1ps
// dpram_sync: single-clock true dual-port RAM with per-byte write enables,
// request/valid read handshake and a deterministic same-address policy.
// Define DPRAM_OUTREG_EN to add an output register stage on rdata/rvalid
// of both ports (read latency 2 instead of 1).
module dpram_sync #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 12,
    parameter int RD_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rvalid,
    input  logic                b_req,
    input  logic                b_we,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_rvalid,
    output logic                collision
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              same_addr;
    logic              a_wr;
    logic              b_wr;
    logic              a_rd;
    logic              b_rd;
    logic              coll_next;
    logic [NB-1:0]     b_be_eff;
    logic [DATA_W-1:0] a_rd_word;
    logic [DATA_W-1:0] b_rd_word;
    logic              a_s1_valid;
    logic              b_s1_valid;
    logic [DATA_W-1:0] a_s1_data;
    logic [DATA_W-1:0] b_s1_data;

    // Classify each port's access; A owns lanes both ports write to one word.
    always_comb begin
        same_addr = (a_addr == b_addr);
        a_wr      = a_req & a_we & ~reset;
        b_wr      = b_req & b_we & ~reset;
        a_rd      = a_req & ~a_we & ~reset;
        b_rd      = b_req & ~b_we & ~reset;
        b_be_eff  = (a_wr & same_addr) ? (b_be & ~a_be) : b_be;
        coll_next = a_req & b_req & same_addr &
                    ((a_we ^ b_we) | (a_we & b_we & (|(a_be & b_be))));
    end

    // Read word per port; write-first mode bypasses the other port's write lanes.
    always_comb begin
        a_rd_word = mem[a_addr];
        b_rd_word = mem[b_addr];
        if (RD_MODE == 1 && same_addr) begin
            for (int i = 0; i < NB; i++) begin
                if (b_wr && b_be[i]) a_rd_word[i*8 +: 8] = b_wdata[i*8 +: 8];
                if (a_wr && a_be[i]) b_rd_word[i*8 +: 8] = a_wdata[i*8 +: 8];
            end
        end
    end

    // Byte-lane memory writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (a_wr && a_be[i])     mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
            if (b_wr && b_be_eff[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
        end
    end

    // First read stage and collision flag; read data holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_s1_valid <= 1'b0;
            b_s1_valid <= 1'b0;
            a_s1_data  <= '0;
            b_s1_data  <= '0;
            collision  <= 1'b0;
        end else begin
            a_s1_valid <= a_rd;
            b_s1_valid <= b_rd;
            if (a_rd) a_s1_data <= a_rd_word;
            if (b_rd) b_s1_data <= b_rd_word;
            collision  <= coll_next;
        end
    end

`ifdef DPRAM_OUTREG_EN
    // Extra output stage for timing closure; flushed by reset like stage one.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_s1_valid;
            b_rvalid <= b_s1_valid;
            if (a_s1_valid) a_rdata <= a_s1_data;
            if (b_s1_valid) b_rdata <= b_s1_data;
        end
    end
`else
    // Single-stage build: outputs come straight from the first read stage.
    always_comb begin
        a_rvalid = a_s1_valid;
        b_rvalid = b_s1_valid;
        a_rdata  = a_s1_data;
        b_rdata  = b_s1_data;
    end
`endif

endmodule

// File: tb/tb_dpram_sync.sv
`timescale 1ns/1ps
// Bench for dpram_sync: two instances (read-first and write-first) share
// the same stimulus and are checked every cycle against a word-level model.
module tb_dpram_sync;
    localparam int DW = 32;
    localparam int AW = 12;
`ifdef DPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          a_req, a_we, b_req, b_we;
    logic [3:0]    a_be, b_be;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;

    logic [DW-1:0] rf_a_rdata, rf_b_rdata, wf_a_rdata, wf_b_rdata;
    logic          rf_a_rvalid, rf_b_rvalid, wf_a_rvalid, wf_b_rvalid;
    logic          rf_coll, wf_coll;

    dpram_sync #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(0)) u_rf (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(rf_a_rdata), .a_rvalid(rf_a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(rf_b_rdata), .b_rvalid(rf_b_rvalid),
        .collision(rf_coll)
    );

    dpram_sync #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(1)) u_wf (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(wf_a_rdata), .a_rvalid(wf_a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(wf_b_rdata), .b_rvalid(wf_b_rvalid),
        .collision(wf_coll)
    );

    int errors = 0;
    int checks = 0;
    int a_pulses = 0;
    bit chk_en = 1'b0;

    // model state: [instance 0=read-first,1=write-first][port 0=A,1=B]
    logic [DW-1:0] mmem [1 << AW];
    logic [DW-1:0] ex_rdata [2][2];
    logic          ex_rvalid [2][2];
    logic [DW-1:0] pend_d [2][2];
    logic          pend_v [2][2];
    logic          ex_coll;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] wd,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (be[l]) r[l*8 +: 8] = wd[l*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] ad);
        return {ad[7:0], ~ad[7:0], ad[7:0] ^ 8'h5A, 8'hC3};
    endfunction

    // Advance the model by one clock using the inputs sampled at this edge.
    task automatic model_step();
        logic [DW-1:0] rd [2][2];
        logic          cv [2];
        logic          same;
        logic          nv;
        logic [DW-1:0] nd;
        if (reset) begin
            for (int i = 0; i < 2; i++)
                for (int p = 0; p < 2; p++) begin
                    ex_rvalid[i][p] = 1'b0;
                    ex_rdata[i][p]  = '0;
                    pend_v[i][p]    = 1'b0;
                    pend_d[i][p]    = '0;
                end
            ex_coll = 1'b0;
            return;
        end
        same  = (a_addr == b_addr);
        cv[0] = a_req && !a_we;
        cv[1] = b_req && !b_we;
        rd[0][0] = mmem[a_addr];
        rd[0][1] = mmem[b_addr];
        rd[1][0] = (b_req && b_we && same) ? merge(mmem[a_addr], b_wdata, b_be) : mmem[a_addr];
        rd[1][1] = (a_req && a_we && same) ? merge(mmem[b_addr], a_wdata, a_be) : mmem[b_addr];
        // B lands first, A overlays: A wins every lane both ports enable
        if (b_req && b_we) mmem[b_addr] = merge(mmem[b_addr], b_wdata, b_be);
        if (a_req && a_we) mmem[a_addr] = merge(mmem[a_addr], a_wdata, a_be);
        ex_coll = a_req && b_req && same &&
                  ((a_we != b_we) || (a_we && b_we && ((a_be & b_be) != 4'h0)));
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++) begin
                if (LAT == 2) begin
                    nv = pend_v[i][p];
                    nd = pend_d[i][p];
                    pend_v[i][p] = cv[p];
                    pend_d[i][p] = rd[i][p];
                end else begin
                    nv = cv[p];
                    nd = rd[i][p];
                end
                ex_rvalid[i][p] = nv;
                if (nv) ex_rdata[i][p] = nd;
            end
    endtask

    // Compare process: every output of both instances, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rf_a_rvalid", 32'(rf_a_rvalid), 32'(ex_rvalid[0][0]));
            chk("rf_b_rvalid", 32'(rf_b_rvalid), 32'(ex_rvalid[0][1]));
            chk("wf_a_rvalid", 32'(wf_a_rvalid), 32'(ex_rvalid[1][0]));
            chk("wf_b_rvalid", 32'(wf_b_rvalid), 32'(ex_rvalid[1][1]));
            chk("rf_a_rdata", rf_a_rdata, ex_rdata[0][0]);
            chk("rf_b_rdata", rf_b_rdata, ex_rdata[0][1]);
            chk("wf_a_rdata", wf_a_rdata, ex_rdata[1][0]);
            chk("wf_b_rdata", wf_b_rdata, ex_rdata[1][1]);
            chk("rf_collision", 32'(rf_coll), 32'(ex_coll));
            chk("wf_collision", 32'(wf_coll), 32'(ex_coll));
            if (rf_a_rvalid) a_pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_a(input logic req, input logic we, input logic [3:0] be,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        a_req = req; a_we = we; a_be = be; a_addr = ad; a_wdata = wd;
    endtask

    task automatic set_b(input logic req, input logic we, input logic [3:0] be,
                         input logic [AW-1:0] ad, input logic [DW-1:0] wd);
        b_req = req; b_we = we; b_be = be; b_addr = ad; b_wdata = wd;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 4'h0, '0, '0);
        set_b(1'b0, 1'b0, 4'h0, '0, '0);
    endtask

    task automatic write_a(input logic [AW-1:0] ad, input logic [DW-1:0] wd, input logic [3:0] be);
        idle();
        set_a(1'b1, 1'b1, be, ad, wd);
        tick();
    endtask

    task automatic read_a(input logic [AW-1:0] ad);
        idle();
        set_a(1'b1, 1'b0, 4'h0, ad, '0);
        tick();
        idle();
        repeat (LAT - 1) tick();
    endtask

    task automatic read_b(input logic [AW-1:0] ad);
        idle();
        set_b(1'b1, 1'b0, 4'h0, ad, '0);
        tick();
        idle();
        repeat (LAT - 1) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rf_a_rvalid"}, 32'(rf_a_rvalid), 0);
        chk({tag, "_rf_b_rvalid"}, 32'(rf_b_rvalid), 0);
        chk({tag, "_wf_a_rvalid"}, 32'(wf_a_rvalid), 0);
        chk({tag, "_wf_b_rvalid"}, 32'(wf_b_rvalid), 0);
        chk({tag, "_rf_a_rdata"}, rf_a_rdata, 0);
        chk({tag, "_wf_b_rdata"}, wf_b_rdata, 0);
        chk({tag, "_collision"}, 32'(rf_coll), 0);
    endtask

    int p0;

    initial begin
        reset = 1'b1;
        idle();
        tick();
        chk_en = 1'b1;
        tick();
        chk_all_zero("reset");
        reset = 1'b0;

        // fill 0x000..0x0FF, both ports writing in parallel
        for (int i = 0; i < 128; i++) begin
            set_a(1'b1, 1'b1, 4'hF, AW'(i), pat(AW'(i)));
            set_b(1'b1, 1'b1, 4'hF, AW'(i + 128), pat(AW'(i + 128)));
            tick();
        end
        idle();
        tick();

        // back-to-back streaming reads, B walking downward
        p0 = a_pulses;
        for (int i = 0; i < 256; i++) begin
            set_a(1'b1, 1'b0, 4'h0, AW'(i), '0);
            set_b(1'b1, 1'b0, 4'h0, AW'(255 - i), '0);
            tick();
        end
        idle();
        repeat (LAT) tick();
        chk("stream_pulses", 32'(a_pulses - p0), 32'd256);
        chk("stream_last_a", rf_a_rdata, 32'hFF00A5C3);
        chk("stream_last_b", rf_b_rdata, 32'h00FF5AC3);

        // basic: lane-0 write from A, read from B
        write_a(12'h123, 32'h0000_0000, 4'hF);
        write_a(12'h123, 32'h5555_55A5, 4'h1);
        read_b(12'h123);
        chk("basic_rvalid", 32'(rf_b_rvalid), 1);
        chk("basic_rf_data", rf_b_rdata, 32'h0000_00A5);
        chk("basic_wf_data", wf_b_rdata, 32'h0000_00A5);

        // byte lanes
        write_a(12'h300, 32'h11223344, 4'hF);
        write_a(12'h300, 32'hAABBCCDD, 4'h5);
        read_a(12'h300);
        chk("byte_lanes", rf_a_rdata, 32'h11BB33DD);

        // write/write collision with overlapping lanes
        set_a(1'b1, 1'b1, 4'h3, 12'h040, 32'h11111111);
        set_b(1'b1, 1'b1, 4'hF, 12'h040, 32'h22222222);
        tick();
        chk("ww_coll_rf", 32'(rf_coll), 1);
        chk("ww_coll_wf", 32'(wf_coll), 1);
        idle();
        tick();
        chk("ww_coll_one_cycle", 32'(rf_coll), 0);
        read_a(12'h040);
        chk("ww_data", rf_a_rdata, 32'h22221111);

        // write/write same address, disjoint lanes: no collision
        set_a(1'b1, 1'b1, 4'h3, 12'h041, 32'h33333333);
        set_b(1'b1, 1'b1, 4'hC, 12'h041, 32'h44444444);
        tick();
        chk("ww_disjoint_coll", 32'(rf_coll), 0);
        read_b(12'h041);
        chk("ww_disjoint_data", wf_b_rdata, 32'h44443333);

        // read/write collision, A writes while B reads
        write_a(12'h007, 32'h00000000, 4'hF);
        set_a(1'b1, 1'b1, 4'hF, 12'h007, 32'hFFFFFFFF);
        set_b(1'b1, 1'b0, 4'h0, 12'h007, '0);
        tick();
        chk("rw_coll_rf", 32'(rf_coll), 1);
        chk("rw_coll_wf", 32'(wf_coll), 1);
        idle();
        repeat (LAT - 1) tick();
        chk("rw_rvalid", 32'(wf_b_rvalid), 1);
        chk("rw_read_first", rf_b_rdata, 32'h00000000);
        chk("rw_write_first", wf_b_rdata, 32'hFFFFFFFF);

        // partial-lane bypass in write-first mode
        set_a(1'b1, 1'b1, 4'h5, 12'h007, 32'hAAAAAAAA);
        set_b(1'b1, 1'b0, 4'h0, 12'h007, '0);
        tick();
        idle();
        repeat (LAT - 1) tick();
        chk("rw_part_rf", rf_b_rdata, 32'hFFFFFFFF);
        chk("rw_part_wf", wf_b_rdata, 32'hFFAAFFAA);

        // mirrored: B writes while A reads
        set_b(1'b1, 1'b1, 4'hF, 12'h007, 32'h12345678);
        set_a(1'b1, 1'b0, 4'h0, 12'h007, '0);
        tick();
        chk("wr_coll", 32'(wf_coll), 1);
        idle();
        repeat (LAT - 1) tick();
        chk("wr_read_first", rf_a_rdata, 32'hFFAAFFAA);
        chk("wr_write_first", wf_a_rdata, 32'h12345678);

        // read/read same address: same data, no collision
        set_a(1'b1, 1'b0, 4'h0, 12'h123, '0);
        set_b(1'b1, 1'b0, 4'h0, 12'h123, '0);
        tick();
        chk("rr_coll", 32'(rf_coll), 0);
        idle();
        repeat (LAT - 1) tick();
        chk("rr_a", rf_a_rdata, 32'h000000A5);
        chk("rr_b", rf_b_rdata, 32'h000000A5);

        // write then read on the same port, consecutive cycles
        write_a(12'h200, 32'hDEADBEEF, 4'hF);
        read_a(12'h200);
        chk("wr_then_rd", rf_a_rdata, 32'hDEADBEEF);

        // a write presented during reset must not land
        reset = 1'b1;
        set_a(1'b1, 1'b1, 4'hF, 12'h200, 32'h0BADF00D);
        tick();
        reset = 1'b0;
        idle();
        tick();
        read_a(12'h200);
        chk("reset_write_ignored", rf_a_rdata, 32'hDEADBEEF);

        // reset mid-read: flushed reads never pulse
        set_a(1'b1, 1'b0, 4'h0, 12'h300, '0);
        set_b(1'b1, 1'b0, 4'h0, 12'h123, '0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        chk_all_zero("midrst");
        tick();
        reset = 1'b0;
        tick();
        chk_all_zero("postrst");
        read_b(12'h300);
        chk("after_reset_read", rf_b_rdata, 32'h11BB33DD);

        idle();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
